// File: rtl/vec_banked_lsu_if.sv
// Request/response bus for the banked vector load/store unit.
// The bench drives the master side; the LSU sits on the slave side.
interface vec_banked_lsu_if #(
  parameter int LANES  = 4,
  parameter int LANE_W = 4,
  parameter int ADDR_W = 4
);
  localparam int CYC_W = $clog2(LANES) + 1;

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [ADDR_W-1:0]         req_base;
  logic [ADDR_W-1:0]         req_stride;
  logic [LANES*LANE_W-1:0]   req_wdata;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [LANES*LANE_W-1:0]   rsp_rdata;
  logic [CYC_W-1:0]          rsp_cycles;

  modport master (
    output req_valid, req_we, req_base, req_stride, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_cycles
  );

  modport slave (
    input  req_valid, req_we, req_base, req_stride, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_cycles
  );
endinterface

// File: rtl/vec_banked_lsu.sv
// Strided vector load/store over LANES-way banked storage (bank = addr mod LANES).
// Lanes hitting the same bank are serialised, lowest lane first, one access per bank per cycle.
//
// state  | meaning
// IDLE   | ready for a request; lane addresses and store data captured on accept
// ACCESS | per-bank grants of pending lanes until the pending mask empties
// RESP   | result held; rsp_valid rises one cycle after entry, exit on rsp_ready
module vec_banked_lsu #(
  parameter int LANES  = 4,
  parameter int LANE_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  vec_banked_lsu_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CYC_W = $clog2(LANES) + 1;
  localparam logic [ADDR_W-1:0] BANK_MASK = ADDR_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state_q, state_n;

  logic [LANE_W-1:0]              mem [DEPTH];
  logic [ADDR_W-1:0]              addr_q [LANES];
  logic [ADDR_W-1:0]              addr_n [LANES];
  logic [LANES-1:0][LANE_W-1:0]   wdata_q;
  logic [LANES-1:0][LANE_W-1:0]   gather_q;
  logic [LANES-1:0]               pend_q;
  logic [LANES-1:0]               grant;
  logic                           we_q;
  logic                           rsp_valid_q;
  logic [CYC_W-1:0]               cycles_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      addr_n[i] = bus.req_base + ADDR_W'(i) * bus.req_stride;
    end
  end

  // A lane is granted unless a lower pending lane already claims its bank.
  always_comb begin
    grant = '0;
    for (int i = 0; i < LANES; i++) begin
      grant[i] = pend_q[i];
      for (int j = 0; j < i; j++) begin
        if (pend_q[j] && ((addr_q[j] & BANK_MASK) == (addr_q[i] & BANK_MASK))) begin
          grant[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_n = ACCESS;
      ACCESS:  if ((pend_q & ~grant) == '0) state_n = RESP;
      RESP:    if (rsp_valid_q && bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      gather_q    <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      cycles_q    <= '0;
      for (int i = 0; i < LANES; i++) addr_q[i] <= '0;
      for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            for (int i = 0; i < LANES; i++) addr_q[i] <= addr_n[i];
            we_q     <= bus.req_we;
            wdata_q  <= bus.req_wdata;
            pend_q   <= '1;
            gather_q <= '0;
            cycles_q <= '0;
          end
        end
        ACCESS: begin
          pend_q   <= pend_q & ~grant;
          cycles_q <= cycles_q + CYC_W'(1);
          // Same-address lanes share a bank, so lane order also fixes store order.
          for (int i = 0; i < LANES; i++) begin
            if (grant[i]) begin
              if (we_q) mem[addr_q[i]] <= wdata_q[i];
              else      gather_q[i]    <= mem[addr_q[i]];
            end
          end
        end
        RESP: rsp_valid_q <= !(rsp_valid_q && bus.rsp_ready);
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = gather_q;
  assign bus.rsp_cycles = cycles_q;
endmodule

// File: tb/tb_vec_banked_lsu.sv
// Directed bench for vec_banked_lsu: hand-computed vectors covering latency,
// bank conflicts, address wrap, response back-pressure and mid-operation reset.
module tb_vec_banked_lsu;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vec_banked_lsu_if #(.LANES(4), .LANE_W(4), .ADDR_W(4)) bus ();

  vec_banked_lsu #(.LANES(4), .LANE_W(4), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_req(input logic we, input logic [3:0] base, input logic [3:0] stride,
                          input logic [15:0] wdata);
    bus.req_we     = we;
    bus.req_base   = base;
    bus.req_stride = stride;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.rsp_valid) check_eq("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  // Full operation: returns data, cycle count and latency from the accept edge.
  task automatic do_op(input logic we, input logic [3:0] base, input logic [3:0] stride,
                       input logic [15:0] wdata, output logic [15:0] rd,
                       output logic [2:0] cyc, output int lat);
    send_req(we, base, stride, wdata);
    wait_rsp(lat);
    rd  = bus.rsp_rdata;
    cyc = bus.rsp_cycles;
    finish_rsp();
  endtask

  logic [15:0] rd;
  logic [2:0]  cyc;
  int          lat;
  logic        seen_valid;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_base   = '0;
    bus.req_stride = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rdata",     32'(bus.rsp_rdata), 32'd0);
    check_eq("rst_cycles",    32'(bus.rsp_cycles), 32'd0);

    do_op(1'b0, 4'd0, 4'd1, 16'h0, rd, cyc, lat);
    check_eq("ld0_rdata", 32'(rd), 32'h0000);
    check_eq("ld0_cycles", 32'(cyc), 32'd1);
    check_eq("ld0_latency", 32'(lat), 32'd2);
    check_eq("idle_after_rsp", 32'(bus.req_ready), 32'd1);

    do_op(1'b1, 4'd0, 4'd1, 16'h4321, rd, cyc, lat);
    check_eq("st_unit_cycles", 32'(cyc), 32'd1);
    check_eq("st_unit_rdata", 32'(rd), 32'h0000);
    do_op(1'b0, 4'd0, 4'd1, 16'h0, rd, cyc, lat);
    check_eq("ld_unit_rdata", 32'(rd), 32'h4321);
    check_eq("ld_unit_cycles", 32'(cyc), 32'd1);

    // mem now: 0=1 1=2 2=3 3=4; preload 0,4,8,12 with 5,6,7,8
    do_op(1'b1, 4'd0, 4'd4, 16'h8765, rd, cyc, lat);
    check_eq("st_s4_cycles", 32'(cyc), 32'd4);
    do_op(1'b0, 4'd0, 4'd4, 16'h0, rd, cyc, lat);
    check_eq("ld_s4_rdata", 32'(rd), 32'h8765);
    check_eq("ld_s4_cycles", 32'(cyc), 32'd4);
    check_eq("ld_s4_latency", 32'(lat), 32'd5);
    // addrs 0,2,4,6 -> 5,3,6,0
    do_op(1'b0, 4'd0, 4'd2, 16'h0, rd, cyc, lat);
    check_eq("ld_s2_cycles", 32'(cyc), 32'd2);
    check_eq("ld_s2_rdata", 32'(rd), 32'h0635);
    check_eq("ld_s2_latency", 32'(lat), 32'd3);

    do_op(1'b1, 4'd5, 4'd0, 16'h4321, rd, cyc, lat);
    check_eq("st_s0_cycles", 32'(cyc), 32'd4);
    do_op(1'b0, 4'd5, 4'd0, 16'h0, rd, cyc, lat);
    check_eq("ld_s0_rdata", 32'(rd), 32'h4444);
    check_eq("ld_s0_cycles", 32'(cyc), 32'd4);

    // addrs 1,0,15,14 -> 2,5,0,0; hold response under back-pressure
    send_req(1'b0, 4'd1, 4'd15, 16'h0);
    wait_rsp(lat);
    check_eq("wrap_latency", 32'(lat), 32'd2);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        bus.req_we     = 1'b1;
        bus.req_base   = 4'd1;
        bus.req_stride = 4'd1;
        bus.req_wdata  = 16'hFFFF;
        bus.req_valid  = 1'b1;
      end else begin
        bus.req_valid  = 1'b0;
      end
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("hold_rdata", 32'(bus.rsp_rdata), 32'h0052);
      check_eq("hold_cycles", 32'(bus.rsp_cycles), 32'd1);
      check_eq("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    finish_rsp();
    check_eq("hold_release_valid", 32'(bus.rsp_valid), 32'd0);
    // mem 1..4 = 2,3,4,6 must be untouched by the ignored store
    do_op(1'b0, 4'd1, 4'd1, 16'h0, rd, cyc, lat);
    check_eq("ignored_req_rdata", 32'(rd), 32'h6432);

    // reset lands on the second ACCESS edge of a stride-4 store
    send_req(1'b1, 4'd0, 4'd4, 16'hAAAA);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("midrst_cycles", 32'(bus.rsp_cycles), 32'd0);
    seen_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen_valid = 1'b1;
    end
    check_eq("midrst_no_rsp", 32'(seen_valid), 32'd0);
    do_op(1'b0, 4'd0, 4'd1, 16'h0, rd, cyc, lat);
    check_eq("midrst_ld_rdata", 32'(rd), 32'h0000);
    do_op(1'b0, 4'd0, 4'd4, 16'h0, rd, cyc, lat);
    check_eq("midrst_ld_s4_rdata", 32'(rd), 32'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
